branch_predict_resolve_unit: RTL
================================

Name: branch_predict_resolve_unit

Overview:
Parametrised successor to the single-cycle beq/bne flush logic. It provides a branch-history table (BHT) of 2-bit saturating counters for IF-stage direction prediction. It resolves all six RV32I conditional branches in EX on real operand data, and on a misprediction it raises IF/ID flushes plus a redirect PC. It also keeps saturating branch and mispredict statistics counters.

Parameters:
XLEN, 32, operand and PC width
BHT_ENTRIES, 16, number of 2-bit counters; power of 2, at least 2; IDX_W = log2(BHT_ENTRIES)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  pipeline freeze; blocks BHT and statistics updates
if_pc  in  XLEN  fetch PC for prediction lookup
pred_taken  out  1  predicted direction for if_pc (combinational)
ex_branch  in  1  EX-stage instruction is a conditional branch
ex_funct3  in  3  branch type
ex_rs1_data  in  XLEN  forwarded rs1 value
ex_rs2_data  in  XLEN  forwarded rs2 value
ex_pc  in  XLEN  PC of the EX branch
ex_target  in  XLEN  computed branch target
ex_pred_taken  in  1  prediction carried down the pipe with the branch
flush_if  out  1  kill IF/ID register contents
flush_id  out  1  kill ID/EX register contents
redirect_valid  out  1  load redirect_pc into the PC
redirect_pc  out  XLEN  corrected fetch address
branch_count  out  CNT_W  resolved branches
mispredict_count  out  CNT_W  mispredicted branches

Behaviour:
- Reset (async, rst_n=0):
  - All BHT counters go to 2'b01 (weakly not-taken).
  - branch_count and mispredict_count go to 0.
  - While in reset, pred_taken=0 and flush_if, flush_id, redirect_valid are 0.
  - redirect_pc is 0 whenever redirect_valid=0.
- Index: idx = pc[IDX_W+1:2]. PC bits [1:0] are ignored.
- Lookup: pred_taken = BHT[idx(if_pc)][1]. Purely combinational, zero latency.
- Resolution in EX (combinational):
  - actual = (rs1==rs2) for funct3 000 beq; (rs1!=rs2) for 001 bne.
  - Signed rs1<rs2 for 100 blt; signed rs1>=rs2 for 101 bge.
  - Unsigned rs1<rs2 for 110 bltu; unsigned rs1>=rs2 for 111 bgeu.
  - valid_br = ex_branch & (funct3 is not 010 or 011). Illegal funct3 is fully ignored: no flush, no update, no count.
  - mispredict = valid_br & (actual != ex_pred_taken).
- Flush and redirect:
  - flush_if = flush_id = redirect_valid = mispredict. These are combinational and asserted in the same cycle as EX, independent of stall.
  - redirect_pc = ex_target if actual=1, or ex_pc+4 if actual=0 (modulo 2^XLEN, wraps). It is 0 when there is no mispredict.
- Registered update at posedge, only when valid_br & !stall:
  - BHT[idx(ex_pc)] increments if actual=1 and decrements if actual=0, saturating at 00 and 11.
  - branch_count += 1, saturating at all-ones.
  - mispredict_count += 1 if mispredict, saturating at all-ones.
- Stall: a branch held in EX across N stalled cycles is updated and counted exactly once, on its first cycle with stall=0. Flush outputs stay asserted throughout the stall.
- Same-cycle lookup and update of one index: pred_taken returns the pre-update value. There is no bypass; the new value is visible next cycle.
- Reset mid-operation: all state clears immediately. A pending update is lost.

Test Plan:
- Reset, then if_pc=0x100 -> pred_taken=0; counts 0. BHT entry 0 reads 01 (check via hierarchy).
- beq, rs1=rs2=5, ex_pred_taken=0, ex_target=0x200, ex_pc=0x80 -> flush_if=flush_id=redirect_valid=1, redirect_pc=0x200. Next cycle: pred_taken for 0x80 is 1, branch_count=1, mispredict_count=1.
- blt, rs1=0xFFFFFFFF, rs2=1, pred=1 -> actual taken, no flush. bltu with the same operands, pred=1 -> mispredict, redirect_pc=ex_pc+4.
- Four taken updates, then one not-taken on the same index -> counter goes 01→10→11→11→11→10; pred_taken stays 1 after the not-taken update.
- Branch held with stall=1 for 3 cycles, then released -> branch_count increments by exactly 1; flush is high in all 4 cycles.
- funct3=010 with ex_branch=1 -> no flush, counters unchanged. Counter preloaded to 0xFFFF plus one more branch -> stays 0xFFFF. ex_pc=0xFFFFFFFC, mispredicted not-taken -> redirect_pc=0x0.

Source files
------------

// File: rtl/branch_predict_resolve_unit.sv
// Branch direction predictor (2-bit saturating BHT) with EX-stage resolution,
// misprediction flush/redirect generation and saturating branch statistics.
module branch_predict_resolve_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pred_taken,
  input  logic             ex_branch,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_rs1_data,
  input  logic [XLEN-1:0]  ex_rs2_data,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  output logic             flush_if,
  output logic             flush_id,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             actual;
  logic             valid_br;
  logic             mispredict;
  logic             do_update;

  // PC bits outside the index field never influence the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  assign pred_taken = rst_n & bht[if_idx][1];

  always_comb begin
    actual = 1'b0;
    case (ex_funct3)
      3'b000:  actual = (ex_rs1_data == ex_rs2_data);
      3'b001:  actual = (ex_rs1_data != ex_rs2_data);
      3'b100:  actual = ($signed(ex_rs1_data) <  $signed(ex_rs2_data));
      3'b101:  actual = ($signed(ex_rs1_data) >= $signed(ex_rs2_data));
      3'b110:  actual = (ex_rs1_data <  ex_rs2_data);
      3'b111:  actual = (ex_rs1_data >= ex_rs2_data);
      default: actual = 1'b0;
    endcase
  end

  // funct3 010/011 are not branches; they must leave every output and state alone.
  assign valid_br   = ex_branch & (ex_funct3[2:1] != 2'b01);
  assign mispredict = rst_n & valid_br & (actual != ex_pred_taken);
  assign do_update  = valid_br & ~stall;

  assign flush_if       = mispredict;
  assign flush_id       = mispredict;
  assign redirect_valid = mispredict;

  always_comb begin
    redirect_pc = '0;
    if (mispredict) begin
      if (actual) redirect_pc = ex_target;
      else        redirect_pc = ex_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (do_update) begin
      if (actual && (bht[ex_idx] != 2'b11)) begin
        bht[ex_idx] <= bht[ex_idx] + 2'b01;
      end else if (!actual && (bht[ex_idx] != 2'b00)) begin
        bht[ex_idx] <= bht[ex_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (do_update) begin
      if (branch_count != '1) begin
        branch_count <= branch_count + CNT_W'(1);
      end
      if (mispredict && (mispredict_count != '1)) begin
        mispredict_count <= mispredict_count + CNT_W'(1);
      end
    end
  end

endmodule
